relay_pulse_scheduler: RTL
==========================

Name: relay_pulse_scheduler

Overview:
- Sequences the H-bridge drive pulses for the front-panel latching signal relays.
- Accepts single-cycle switch requests per channel and holds one pending request per channel.
- Grants one coil at a time, round-robin, so that only one coil draws current at once.
- Drives relay_a/relay_b with a timed pulse followed by a dead gap, and tracks the last commanded position of each relay.

Parameters:
- NUM_RELAYS, 4: number of relay channels (1..16).
- PULSE_CYCLES, 1250000: coil energise time in clk_125mhz cycles (10 ms).
- GAP_CYCLES, 125000: all-off dead time after each pulse, in cycles (1 ms).
- CNT_WIDTH, 21: pulse/gap counter width. Must hold max(PULSE_CYCLES, GAP_CYCLES).

Ports:
- clk_125mhz  in  1  system clock; all logic is in this single domain.
- rst  in  1  synchronous reset, active high.
- req_en  in  1  request strobe; one request per cycle.
- req_channel  in  $clog2(NUM_RELAYS)  target channel of the request.
- req_dir  in  1  requested position: 1 = drive A-side (relay_a high), 0 = drive B-side.
- req_err  out  1  one-cycle pulse when a request names a channel >= NUM_RELAYS.
- relay_a  out  NUM_RELAYS  H-bridge A-side drive, registered.
- relay_b  out  NUM_RELAYS  H-bridge B-side drive, registered.
- busy  out  1  high whenever the FSM is not IDLE or any channel is pending.
- done  out  1  one-cycle pulse at the end of each pulse phase.
- done_channel  out  $clog2(NUM_RELAYS)  channel that completed; valid while done is high.
- position  out  NUM_RELAYS  last pulsed direction per channel.
- position_valid  out  NUM_RELAYS  set once a channel has been pulsed since reset.

Behaviour:
- Reset: all outputs 0; pending[] cleared; the round-robin pointer is set so that channel 0 has first priority; FSM in IDLE; counter 0. A reset asserted mid-pulse drives relay_a/relay_b to 0 on the next edge.
- Request latch: on req_en with a valid channel, pending[ch] is set and pend_dir[ch] = req_dir, both visible the next cycle. A request to an already pending channel overwrites pend_dir; only one request per channel is held. A request to the channel currently being pulsed sets it pending again, so it is re-pulsed after the gap. An invalid channel is dropped and req_err pulses on the next cycle.
- FSM IDLE:
  - If any pending bit is set, grant the first pending channel at or after rr_ptr, wrapping modulo NUM_RELAYS.
  - Same edge: clear pending[grant]; capture grant and direction; load the counter; go to PULSE; rr_ptr = grant+1, wrapping.
  - A request arriving in the same cycle as the grant, for the granted channel, wins: pending stays set with the new direction.
- FSM PULSE:
  - relay_a[grant] = dir, relay_b[grant] = ~dir; all other bits 0.
  - Outputs are high for exactly PULSE_CYCLES cycles, starting the cycle after the grant edge.
  - On the last pulse cycle's edge: position[grant] = dir, position_valid[grant] = 1, done = 1 with done_channel = grant for one cycle; go to GAP.
- FSM GAP:
  - All relay outputs 0 for exactly GAP_CYCLES cycles, then return to IDLE.
  - IDLE takes one cycle before the next grant, so back-to-back grants are PULSE_CYCLES + GAP_CYCLES + 1 cycles apart.
- Invariants:
  - relay_a & relay_b is always 0.
  - At most one bit of (relay_a | relay_b) is set.
  - No coil is ever energised outside PULSE.
- Counter: down-counter, CNT_WIDTH bits, never wraps. PULSE_CYCLES and GAP_CYCLES of 0 are illegal; an elaboration-time assertion rejects them.

Test Plan (PULSE_CYCLES=8, GAP_CYCLES=4, NUM_RELAYS=4):
- Single request, req_en ch2 dir1 at cycle 0:
  - Pending cycle 1, grant edge cycle 1.
  - relay_a = 4'b0100 on cycles 2-9, relay_b = 0.
  - done with done_channel=2 at cycle 9; position[2]=1 and position_valid[2]=1 from cycle 10.
  - Outputs 0 on cycles 10-13; busy low from cycle 15.
- Simultaneous pending ch0,ch1,ch3 with rr_ptr=1 → service order 1, 3, 0. Pulse starts 13 cycles apart; never two bits high.
- Overwrite: ch1 dir1 then ch1 dir0 while ch0 is pulsing → exactly one ch1 pulse, on relay_b[1], then position[1]=0.
- Re-request of the active channel mid-PULSE → a second pulse on that channel after the gap.
- req_channel=5 with NUM_RELAYS=4 (3-bit port override) → req_err pulses once; no pending bit changes.
- rst asserted on pulse cycle 4 → relay_a/relay_b = 0 the next cycle; pending, position and position_valid all 0; no done pulse.

Source files
------------

// File: rtl/relay_pulse_scheduler.sv
// relay_pulse_scheduler
//
// Sequences H-bridge drive pulses for latching signal relays. Each channel
// holds at most one pending switch request. A round-robin arbiter grants one
// coil at a time. The granted coil is driven for PULSE_CYCLES cycles. A dead
// gap of GAP_CYCLES cycles follows with every coil off. The last commanded
// position of each relay is tracked.
//
// Handshake: req_en is a single-cycle strobe with no ready. Every request
// naming a valid channel is accepted on the cycle it is presented. A newer
// request to a channel that is still pending replaces the older direction.
// A request naming a channel >= NUM_RELAYS is dropped, and req_err pulses on
// the following cycle.
//
// Ports:
//   clk_125mhz      system clock (single domain)
//   rst             synchronous reset, active high
//   req_en          request strobe
//   req_channel     target channel of the request
//   req_dir         1 = drive A-side, 0 = drive B-side
//   req_err         one-cycle pulse after a request to an invalid channel
//   relay_a/b       registered H-bridge drives, at most one coil active
//   busy            FSM not idle or a request pending (registered)
//   done            high on the last cycle of each pulse phase
//   done_channel    channel finishing its pulse while done is high
//   position        last pulsed direction per channel
//   position_valid  channel has been pulsed since reset
//
// The FSM state is available as the internal signal `state` for observation.

module relay_pulse_scheduler #(
  parameter int NUM_RELAYS   = 4,
  parameter int PULSE_CYCLES = 1250000,
  parameter int GAP_CYCLES   = 125000,
  parameter int CNT_WIDTH    = 21,
  parameter int CH_WIDTH     = (NUM_RELAYS > 1) ? $clog2(NUM_RELAYS) : 1
) (
  input  logic                  clk_125mhz,
  input  logic                  rst,
  input  logic                  req_en,
  input  logic [CH_WIDTH-1:0]   req_channel,
  input  logic                  req_dir,
  output logic                  req_err,
  output logic [NUM_RELAYS-1:0] relay_a,
  output logic [NUM_RELAYS-1:0] relay_b,
  output logic                  busy,
  output logic                  done,
  output logic [CH_WIDTH-1:0]   done_channel,
  output logic [NUM_RELAYS-1:0] position,
  output logic [NUM_RELAYS-1:0] position_valid
);

  if (PULSE_CYCLES <= 0 || GAP_CYCLES <= 0) begin : g_bad_timing
    $error("relay_pulse_scheduler: PULSE_CYCLES and GAP_CYCLES must be nonzero");
  end
  if (PULSE_CYCLES >= (2 ** CNT_WIDTH) || GAP_CYCLES >= (2 ** CNT_WIDTH)) begin : g_bad_cnt
    $error("relay_pulse_scheduler: CNT_WIDTH too small for pulse/gap length");
  end
  if (NUM_RELAYS < 1 || NUM_RELAYS > 16) begin : g_bad_num
    $error("relay_pulse_scheduler: NUM_RELAYS out of range");
  end

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t                state, state_nx;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nx;
  logic [NUM_RELAYS-1:0] pending, pending_nx;
  logic [NUM_RELAYS-1:0] pend_dir, pend_dir_nx;
  logic [CH_WIDTH-1:0]   rr_ptr;
  logic [CH_WIDTH-1:0]   cur_ch;
  logic                  cur_dir;
  logic [CH_WIDTH-1:0]   grant_ch;
  logic                  grant_found;
  logic                  grant_take;
  logic                  last_pulse;
  logic                  req_valid;
  logic [CH_WIDTH-1:0]   drive_ch;
  logic                  drive_dir;

  assign req_valid = req_en && (int'(req_channel) < NUM_RELAYS);

  // Round-robin search: walk the offsets from high to low, so the pending
  // channel closest to rr_ptr (offset 0 first) is the last to be written.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = NUM_RELAYS - 1; i >= 0; i--) begin
      if (pending[(int'(rr_ptr) + i) % NUM_RELAYS]) begin
        grant_found = 1'b1;
        grant_ch    = CH_WIDTH'((int'(rr_ptr) + i) % NUM_RELAYS);
      end
    end
  end

  // Next-state logic. The counter is loaded with the phase length and leaves
  // the phase on the cycle where it reads 1, giving exactly N cycles per phase.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    grant_take = 1'b0;
    last_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nx   = PULSE;
          cnt_nx     = CNT_WIDTH'(PULSE_CYCLES);
          grant_take = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == CNT_WIDTH'(1)) begin
          state_nx   = GAP;
          cnt_nx     = CNT_WIDTH'(GAP_CYCLES);
          last_pulse = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_WIDTH'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_WIDTH'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A request is applied after the grant clears the bit. A request for the
  // channel being granted therefore stays pending, with its new direction.
  always_comb begin
    pending_nx  = pending;
    pend_dir_nx = pend_dir;
    if (grant_take) pending_nx[grant_ch] = 1'b0;
    if (req_valid) begin
      pending_nx[req_channel]  = 1'b1;
      pend_dir_nx[req_channel] = req_dir;
    end
  end

  // The relay registers are driven from the next state. The coil therefore
  // turns on the cycle after the grant edge and off the cycle after the last
  // pulse.
  assign drive_ch  = grant_take ? grant_ch : cur_ch;
  assign drive_dir = grant_take ? pend_dir[grant_ch] : cur_dir;

  assign done         = last_pulse;
  assign done_channel = last_pulse ? cur_ch : '0;

  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pending        <= '0;
      pend_dir       <= '0;
      rr_ptr         <= '0;
      cur_ch         <= '0;
      cur_dir        <= 1'b0;
      relay_a        <= '0;
      relay_b        <= '0;
      position       <= '0;
      position_valid <= '0;
      req_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pending  <= pending_nx;
      pend_dir <= pend_dir_nx;
      req_err  <= req_en && !req_valid;
      busy     <= (state != IDLE) || (|pending);
      if (grant_take) begin
        cur_ch  <= grant_ch;
        cur_dir <= pend_dir[grant_ch];
        rr_ptr  <= CH_WIDTH'((int'(grant_ch) + 1) % NUM_RELAYS);
      end
      if (state_nx == PULSE) begin
        relay_a <= (NUM_RELAYS'(1) << drive_ch) & {NUM_RELAYS{drive_dir}};
        relay_b <= (NUM_RELAYS'(1) << drive_ch) & {NUM_RELAYS{~drive_dir}};
      end else begin
        relay_a <= '0;
        relay_b <= '0;
      end
      if (last_pulse) begin
        position[cur_ch]       <= cur_dir;
        position_valid[cur_ch] <= 1'b1;
      end
    end
  end

endmodule
